// File: rtl/cmos_dvp_capture.sv
// DVP capture stage: skips settling frames after configuration, packs byte pairs into RGB565 pixels, and checks line/frame geometry.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces camera data with a position-coded test pattern.
module cmos_dvp_capture #(
   parameter int FRAME_SKIP = 10,
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720
) (
   input  logic        cmos_pclk,
   input  logic        camera_rstn,
   input  logic        reg_conf_done,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   output logic        pix_de,
   output logic [15:0] pix_data,
   output logic        pix_vs,
   output logic [15:0] frame_cnt,
   output logic        line_err,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_WAIT_VS,
      ST_ACTIVE
   } state_t;

   localparam logic [15:0] SKIP_LAST = 16'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);
   localparam logic [11:0] H_EXP     = 12'(H_ACTIVE);
   localparam logic [11:0] V_EXP     = 12'(V_ACTIVE);

   state_t      state_q, state_d;
   logic [15:0] skip_q, skip_d;

   logic        conf_meta, conf_sync;
   logic        vs_d, vs_d2, href_d, href_d2;
   logic [7:0]  data_d;

   logic        phase;
   logic [7:0]  hi;
   logic [11:0] pix_x, pix_y;

   logic        vs_rise, href_fall;
   logic        active, enter;
   logic [11:0] pix_y_inc, pix_y_end;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge cmos_pclk or negedge camera_rstn) begin
      if (!camera_rstn) begin
         conf_meta <= 1'b0;
         conf_sync <= 1'b0;
         vs_d      <= 1'b0;
         vs_d2     <= 1'b0;
         href_d    <= 1'b0;
         href_d2   <= 1'b0;
         data_d    <= 8'h00;
      end else begin
         conf_meta <= reg_conf_done;
         conf_sync <= conf_meta;
         vs_d      <= cmos_vsync;
         vs_d2     <= vs_d;
         href_d    <= cmos_href;
         href_d2   <= href_d;
         data_d    <= cmos_data;
      end
   end

   assign vs_rise   = vs_d & ~vs_d2;
   assign href_fall = ~href_d & href_d2;
   assign active    = conf_sync && (state_q == ST_ACTIVE);
   assign enter     = conf_sync && (state_q == ST_WAIT_VS) && vs_rise;
   assign pix_y_inc = (pix_y == 12'hFFF) ? pix_y : pix_y + 12'd1;
   // A line ending on the same edge as vsync is counted before the frame check.
   assign pix_y_end = href_fall ? pix_y_inc : pix_y;

   always_ff @(posedge cmos_pclk or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state_q <= ST_IDLE;
         skip_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end

   // NOTE: outputs of always_comb get defaults first so no path leaves them unassigned (no latch).
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      if (!conf_sync) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               skip_d  = 16'h0000;
               state_d = (FRAME_SKIP == 0) ? ST_WAIT_VS : ST_SKIP;
            end
            ST_SKIP: begin
               if (vs_rise) begin
                  if (skip_q == SKIP_LAST) state_d = ST_WAIT_VS;
                  else                     skip_d  = skip_q + 16'd1;
               end
            end
            ST_WAIT_VS: begin
               if (vs_rise) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge cmos_pclk or negedge camera_rstn) begin
      if (!camera_rstn) begin
         pix_de    <= 1'b0;
         pix_data  <= 16'h0000;
         pix_vs    <= 1'b0;
         frame_cnt <= 16'h0000;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
         phase     <= 1'b0;
         hi        <= 8'h00;
         pix_x     <= 12'h000;
         pix_y     <= 12'h000;
      end else begin
         pix_de <= 1'b0;
         pix_vs <= 1'b0;
         if (!active) begin
            phase <= 1'b0;
            pix_x <= 12'h000;
            pix_y <= 12'h000;
         end else begin
            if (href_d) begin
               if (!phase) begin
                  phase <= 1'b1;
`ifndef CAPTURE_TEST_PATTERN_EN
                  hi    <= data_d;
`endif
               end else begin
                  phase  <= 1'b0;
                  pix_de <= 1'b1;
                  pix_x  <= (pix_x == 12'hFFF) ? pix_x : pix_x + 12'd1;
`ifdef CAPTURE_TEST_PATTERN_EN
                  pix_data <= {pix_y[4:0], pix_x[10:5], pix_x[4:0]};
`else
                  pix_data <= {hi, data_d};
`endif
               end
            end else if (href_fall) begin
               if (phase || (pix_x != H_EXP)) line_err <= 1'b1;
               phase <= 1'b0;
               pix_x <= 12'h000;
               pix_y <= pix_y_inc;
            end
            if (vs_rise) begin
               if (pix_y_end != V_EXP) frame_err <= 1'b1;
               pix_y <= 12'h000;
            end
         end
         if (enter || (active && vs_rise)) begin
            pix_vs    <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Self-checking bench for cmos_dvp_capture: randomized DVP frames against a frame-level reference model.
module tb_cmos_dvp_capture;

   localparam int FRAME_SKIP = 2;
   localparam int H_ACTIVE   = 4;
   localparam int V_ACTIVE   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reg_conf_done = 1'b0;
   logic        cmos_vsync = 1'b0;
   logic        cmos_href = 1'b0;
   logic [7:0]  cmos_data = 8'h00;
   logic        pix_de;
   logic [15:0] pix_data;
   logic        pix_vs;
   logic [15:0] frame_cnt;
   logic        line_err;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] exp_q[$];
   logic [7:0]  line_buf [0:63];
   bit          conf_model = 1'b0;
   int          vs_idx = 0;
   int          line_cnt = 0;
   logic [15:0] exp_fc = 16'h0000;
   bit          exp_le = 1'b0;
   bit          exp_fe = 1'b0;
   int          exp_vs = 0;
   int          vs_seen = 0;

   cmos_dvp_capture #(
      .FRAME_SKIP(FRAME_SKIP),
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE)
   ) dut (
      .cmos_pclk    (clk),
      .camera_rstn  (rst_n),
      .reg_conf_done(reg_conf_done),
      .cmos_vsync   (cmos_vsync),
      .cmos_href    (cmos_href),
      .cmos_data    (cmos_data),
      .pix_de       (pix_de),
      .pix_data     (pix_data),
      .pix_vs       (pix_vs),
      .frame_cnt    (frame_cnt),
      .line_err     (line_err),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pixel scoreboard: every strobe must match the next expected pixel.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pix_vs) vs_seen++;
         if (pix_de) begin
            if (exp_q.size() == 0) check("unexpected_pix_de", {31'b0, pix_de}, 32'd0);
            else                   check("pix_data", {16'b0, pix_data}, {16'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic bit capturing();
      return conf_model && (vs_idx > FRAME_SKIP);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) line_buf[i] = 8'($urandom);
   endtask

   // Drives one href line from line_buf; optionally checks the two-edge latency cycle by cycle.
   task automatic drive_line(input int n, input bit lat);
      if (capturing()) begin
         for (int p = 0; p < n / 2; p++) exp_q.push_back({line_buf[2*p], line_buf[2*p+1]});
         line_cnt++;
         if ((n % 2) != 0 || (n / 2) != H_ACTIVE) exp_le = 1'b1;
      end
      for (int j = 0; j < n; j++) begin
         tick();
         if (lat && j >= 3 && (j % 2) == 1) begin
            check("lat_de_high", {31'b0, pix_de}, 32'd1);
            check("lat_data", {16'b0, pix_data}, {16'b0, line_buf[j-3], line_buf[j-2]});
         end else if (lat) begin
            check("lat_de_low", {31'b0, pix_de}, 32'd0);
         end
         cmos_href = 1'b1;
         cmos_data = line_buf[j];
      end
      tick();
      cmos_href = 1'b0;
      cmos_data = 8'($urandom);
      repeat ($urandom_range(2, 4)) tick();
   endtask

   task automatic send_vs();
      if (conf_model) begin
         vs_idx++;
         if (vs_idx > FRAME_SKIP) begin
            exp_fc++;
            exp_vs++;
         end
         if (vs_idx > FRAME_SKIP + 1 && line_cnt != V_ACTIVE) exp_fe = 1'b1;
      end
      line_cnt = 0;
      tick();
      cmos_vsync = 1'b1;
      tick();
      tick();
      cmos_vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_frame(input int nlines);
      send_vs();
      for (int l = 0; l < nlines; l++) begin
         fill_random(2 * H_ACTIVE);
         drive_line(2 * H_ACTIVE, 1'b0);
      end
   endtask

   task automatic check_status(input string tag);
      repeat (3) tick();
      check({tag, "_frame_cnt"}, {16'b0, frame_cnt}, {16'b0, exp_fc});
      check({tag, "_line_err"}, {31'b0, line_err}, {31'b0, exp_le});
      check({tag, "_frame_err"}, {31'b0, frame_err}, {31'b0, exp_fe});
      check({tag, "_vs_count"}, 32'(vs_seen), 32'(exp_vs));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pix_de"}, {31'b0, pix_de}, 32'd0);
      check({tag, "_pix_data"}, {16'b0, pix_data}, 32'd0);
      check({tag, "_pix_vs"}, {31'b0, pix_vs}, 32'd0);
      check({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 32'd0);
      check({tag, "_line_err"}, {31'b0, line_err}, 32'd0);
      check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
   endtask

   initial begin
      // reset state
      #2;
      check_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // startup skip: two discarded frames, then two captured
      reg_conf_done = 1'b1;
      conf_model    = 1'b1;
      repeat (6) tick();
      for (int f = 0; f < 4; f++) send_frame(V_ACTIVE);
      check_status("skip");

      // packing and latency with fixed RGB565 bytes
      send_vs();
      line_buf[0] = 8'hF8;
      line_buf[1] = 8'h1F;
      line_buf[2] = 8'h07;
      line_buf[3] = 8'hE0;
      for (int i = 4; i < 2 * H_ACTIVE; i++) line_buf[i] = 8'($urandom);
      drive_line(2 * H_ACTIVE, 1'b1);
      fill_random(2 * H_ACTIVE);
      drive_line(2 * H_ACTIVE, 1'b0);
      check_status("pack");

      // odd-length line: trailing byte dropped, line_err set
      send_vs();
      fill_random(7);
      drive_line(7, 1'b0);
      fill_random(2 * H_ACTIVE);
      drive_line(2 * H_ACTIVE, 1'b0);
      check_status("odd_line");

      // short frame: one line, flagged on the following vsync
      send_frame(1);
      send_vs();
      check_status("short_frame");
      fill_random(2 * H_ACTIVE);
      drive_line(2 * H_ACTIVE, 1'b0);

      // configuration drop mid-line: the byte pairs already in flight still emerge
      fill_random(2 * H_ACTIVE);
      exp_q.push_back({line_buf[0], line_buf[1]});
      exp_q.push_back({line_buf[2], line_buf[3]});
      for (int j = 0; j < 2 * H_ACTIVE; j++) begin
         tick();
         if (j == 5) check("drop_last_de", {31'b0, pix_de}, 32'd1);
         if (j >= 6) check("drop_de_low", {31'b0, pix_de}, 32'd0);
         cmos_href = 1'b1;
         cmos_data = line_buf[j];
         if (j == 3) reg_conf_done = 1'b0;
      end
      tick();
      cmos_href  = 1'b0;
      conf_model = 1'b0;
      repeat (4) tick();
      send_frame(V_ACTIVE);
      check_status("conf_off");

      // configuration returns: skip sequence restarts, frame_cnt retained
      reg_conf_done = 1'b1;
      conf_model    = 1'b1;
      vs_idx        = 0;
      repeat (6) tick();
      for (int f = 0; f < 4; f++) send_frame(V_ACTIVE);
      check_status("conf_back");

      // asynchronous reset while href is high
      send_vs();
      fill_random(4);
      exp_q.push_back({line_buf[0], line_buf[1]});
      for (int j = 0; j < 4; j++) begin
         tick();
         cmos_href = 1'b1;
         cmos_data = line_buf[j];
      end
      #5;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      check("rst_pending_pixels", 32'(exp_q.size()), 32'd0);
      cmos_href  = 1'b0;
      cmos_vsync = 1'b0;
      exp_q.delete();
      exp_fc   = 16'h0000;
      exp_le   = 1'b0;
      exp_fe   = 1'b0;
      vs_idx   = 0;
      line_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) tick();
      for (int f = 0; f < 3; f++) send_frame(V_ACTIVE);
      check_status("after_rst");
      send_vs();
      check_status("final");
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
